// File: rtl/itrx_amba4_apb_pkg.sv
// AMBA4 APB shared types: transfer direction, protection bits,
// requester FSM states and the requester response bundle.
package itrx_amba4_apb_pkg;

  typedef enum logic {
    READ  = 1'b0,
    WRITE = 1'b1
  } te_pwrite;

  typedef struct packed {
    logic instr;
    logic nsec;
    logic priv;
  } ts_pprot;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS,
    RESP
  } te_apb4_req_state;

  localparam int unsigned APB4_MAX_DW = 32;

  typedef struct packed {
    logic [APB4_MAX_DW-1:0] rdata;
    logic                   err;
    logic                   timeout;
  } ts_apb4_rsp;

endpackage

// File: rtl/itrx_apb4_tmo_cnt.sv
// APB access timeout counter: clr zeroes, en counts up and saturates at MAX.
// Ports: clk, rst_n, clr, en in; done out (this is the MAX-th counted cycle).
module itrx_apb4_tmo_cnt #(
  parameter int unsigned MAX = 0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic done
);

  if (MAX == 0) begin : g_off
    logic unused_ok;
    assign unused_ok = ^{clk, rst_n, clr, en};
    assign done = 1'b0;
  end else begin : g_on
    localparam int unsigned W = $clog2(MAX + 1);
    localparam logic [W-1:0] TOP = W'(MAX);
    localparam logic [W-1:0] LAST = W'(MAX - 1);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt <= '0;
      end else if (clr) begin
        cnt <= '0;
      end else if (en && cnt != TOP) begin
        cnt <= cnt + 1'b1;
      end
    end

    // cnt holds the number of ACCESS cycles already finished
    assign done = (cnt >= LAST);
  end

endmodule

// File: rtl/itrx_apb4_requester.sv
// APB4 requester: one cmd handshake -> one APB4 transfer -> one rsp handshake.
// Ports: cmd_* in (valid/ready), rsp_* out (valid/ready), p* APB4 requester side.
module itrx_apb4_requester
  import itrx_amba4_apb_pkg::*;
#(
  parameter int unsigned AW      = 32,
  parameter int unsigned DW      = 32,
  parameter int unsigned TIMEOUT = 0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic [AW-1:0]   cmd_addr,
  input  te_pwrite        cmd_write,
  input  logic [DW-1:0]   cmd_wdata,
  input  logic [DW/8-1:0] cmd_wstrb,
  input  ts_pprot         cmd_prot,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [DW-1:0]   rsp_rdata,
  output logic            rsp_err,
  output logic            rsp_timeout,
  output logic [AW-1:0]   paddr,
  output te_pwrite        pwrite,
  output logic [DW-1:0]   pwdata,
  output logic [DW/8-1:0] pstrb,
  output ts_pprot         pprot,
  output logic            psel,
  output logic            penable,
  input  logic [DW-1:0]   prdata,
  input  logic            pready,
  input  logic            pslverr
);

  te_apb4_req_state state_q, state_d;
  ts_apb4_rsp       rsp_q, rsp_d;

  logic [AW-1:0]   paddr_d;
  te_pwrite        pwrite_d;
  logic [DW-1:0]   pwdata_d;
  logic [DW/8-1:0] pstrb_d;
  ts_pprot         pprot_d;
  logic            psel_d;
  logic            penable_d;
  logic            accept;
  logic            tmo_done;

  assign cmd_ready   = (state_q == IDLE);
  assign rsp_valid   = (state_q == RESP);
  assign accept      = cmd_valid & cmd_ready;
  assign rsp_rdata   = rsp_q.rdata[DW-1:0];
  assign rsp_err     = rsp_q.err;
  assign rsp_timeout = rsp_q.timeout;

  itrx_apb4_tmo_cnt #(
    .MAX(TIMEOUT)
  ) u_tmo (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (accept),
    .en   (state_q == ACCESS),
    .done (tmo_done)
  );

  always_comb begin
    state_d   = state_q;
    rsp_d     = rsp_q;
    paddr_d   = paddr;
    pwrite_d  = pwrite;
    pwdata_d  = pwdata;
    pstrb_d   = pstrb;
    pprot_d   = pprot;
    psel_d    = psel;
    penable_d = penable;
    unique case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          state_d   = SETUP;
          paddr_d   = cmd_addr;
          pwrite_d  = cmd_write;
          pwdata_d  = cmd_wdata;
          pstrb_d   = (cmd_write == WRITE) ? cmd_wstrb : '0;
          pprot_d   = cmd_prot;
          psel_d    = 1'b1;
          penable_d = 1'b0;
        end
      end
      SETUP: begin
        state_d   = ACCESS;
        penable_d = 1'b1;
      end
      ACCESS: begin
        if (pready) begin
          state_d       = RESP;
          psel_d        = 1'b0;
          penable_d     = 1'b0;
          rsp_d.rdata   = (pwrite == WRITE) ? '0 : APB4_MAX_DW'(prdata);
          rsp_d.err     = pslverr;
          rsp_d.timeout = 1'b0;
        end else if (tmo_done) begin
          // abort a hung completer; breaks APB on purpose
          state_d       = RESP;
          psel_d        = 1'b0;
          penable_d     = 1'b0;
          rsp_d.rdata   = '0;
          rsp_d.err     = 1'b1;
          rsp_d.timeout = 1'b1;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      rsp_q   <= '0;
      paddr   <= '0;
      pwrite  <= READ;
      pwdata  <= '0;
      pstrb   <= '0;
      pprot   <= '0;
      psel    <= 1'b0;
      penable <= 1'b0;
    end else begin
      state_q <= state_d;
      rsp_q   <= rsp_d;
      paddr   <= paddr_d;
      pwrite  <= pwrite_d;
      pwdata  <= pwdata_d;
      pstrb   <= pstrb_d;
      pprot   <= pprot_d;
      psel    <= psel_d;
      penable <= penable_d;
    end
  end

endmodule
